led_seq_master: RTL
===================

LED_SEQ_MASTER -- requirements
Module: led_seq_master

Interface
REQ-001 Parameter READ_LATENCY, default 1, SHALL give the cycles from read-accept edge to valid avm_readdata (range 1-4).
REQ-002 Parameter CSR_ADDR, default 2'b00, SHALL give the slave register address driven on every transfer.
REQ-003 Ports (name  direction  width  meaning), listed in REQ-004 to REQ-018.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  level, sampled in IDLE; begins sequencing.
REQ-007 stop  in  1  level; requests graceful halt.
REQ-008 clear_error  in  1  clears error and err_count.
REQ-009 period  in  32  dwell cycles between steps; 0 treated as 1.
REQ-010 avm_address  out  2  Avalon-MM address.
REQ-011 avm_chipselect / avm_write / avm_read  out  1 each  Avalon-MM strobes.
REQ-012 avm_writedata  out  32  write data.
REQ-013 avm_readdata  in  32  read data.
REQ-014 avm_waitrequest  in  1  slave stall; transfer accepted on an edge where it is low.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 step_idx  out  2  current pattern index 0..2.
REQ-017 error  out  1  sticky readback-mismatch flag.
REQ-018 err_count  out  8  mismatch count, saturating at 255.

Function
REQ-019 Pattern code SHALL be 10'b0000000001, 10'b0000000010, 10'b0000000100 for step_idx 0, 1, 2; avm_writedata = {22'b0, code}.
REQ-020 FSM states SHALL be IDLE, WRITE, READ, WAIT_RD, DWELL.
REQ-021 IDLE -> WRITE when start=1 and stop=0; start=1 with stop=1 SHALL stay IDLE; start outside IDLE ignored.
REQ-022 WRITE: chipselect=1, write=1, address=CSR_ADDR; all outputs held stable while waitrequest=1; -> READ on accept edge.
REQ-023 READ: chipselect=1, read=1, address=CSR_ADDR; held while waitrequest=1; -> WAIT_RD on accept edge.
REQ-024 WAIT_RD: strobes low; avm_readdata sampled exactly READ_LATENCY cycles after accept edge; then -> DWELL.
REQ-025 Mismatch when readdata[9:0] != code or readdata[31:10] != 0: error set, err_count +1 (saturate).
REQ-026 clear_error SHALL zero error and err_count next edge; coincident mismatch wins (error=1, err_count=1).
REQ-027 DWELL: counter loads max(period,1) on entry, decrements per cycle; at 1 -> WRITE with step_idx advanced 0->1->2->0.
REQ-028 stop seen in WRITE/READ/WAIT_RD SHALL be latched as pending; transfer completes; DWELL entry with pending -> IDLE.
REQ-029 stop=1 in DWELL SHALL -> IDLE next edge; step_idx retained; restart resumes at next step index.
REQ-030 Outside WRITE/READ all strobes SHALL be 0 and avm_writedata 0.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, all strobes 0, avm_address 0, avm_writedata 0, busy 0, step_idx 0, error 0, err_count 0, dwell counter 0, stop-pending 0.
REQ-032 Reset mid-transfer SHALL drop strobes immediately, not awaiting waitrequest.

Structure
REQ-033 Shared package led_seq_pkg SHALL hold the state enum, the three pattern codes and CSR_ADDR default.
REQ-034 Dwell countdown SHALL be sub-module led_seq_timer (load, value, expire); rest in top.

Verification
REQ-035 Reset, period=4, waitrequest=0, echo slave latency 1, start=1 -> writes 0x001, 0x002, 0x004, 0x001; write-to-write spacing 7 cycles; error=0.
REQ-036 waitrequest high 3 cycles during WRITE -> address/writedata/strobes stable 4 cycles, exactly one write accepted.
REQ-037 Slave returns 0x000 for step 1 -> error=1, err_count=1, sequence continues to 0x004; clear_error -> both 0.
REQ-038 stop pulsed during READ -> read completes, IDLE, busy=0, step_idx holds; start -> next write is following code.
REQ-039 reset_n low mid-WRITE with waitrequest=1 -> strobes 0 same cycle, all outputs at reset values.
REQ-040 period=0 and period=1 -> identical timing; 256 forced mismatches -> err_count stays 255.

Source files
------------

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state encoding, pattern codes and register address default
package led_seq_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, DWELL} state_e;
  localparam logic [1:0] CSR_ADDR_DEF = 2'b00;
  localparam logic [9:0] CODE0 = 10'b0000000001;
  localparam logic [9:0] CODE1 = 10'b0000000010;
  localparam logic [9:0] CODE2 = 10'b0000000100;
  function automatic logic [31:0] pattern(input logic [1:0] idx);
    return {22'b0, idx == 2'd0 ? CODE0 : idx == 2'd1 ? CODE1 : CODE2};
  endfunction
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return idx == 2'd2 ? 2'd0 : idx + 2'd1;
  endfunction
endpackage

// File: rtl/led_seq_timer.sv
// led_seq_timer: dwell countdown, loads max(value,1) and flags expiry when it reaches 1
module led_seq_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] value,
  output logic        expire
);
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? (value == 32'd0 ? 32'd1 : value) : cnt_q == 32'd0 ? cnt_q : cnt_q - 32'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire = cnt_q == 32'd1;
endmodule

// File: rtl/led_seq_master.sv
// led_seq_master: Avalon-MM master cycling an LED pattern register with write/readback verify
module led_seq_master import led_seq_pkg::*; #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [1:0]  CSR_ADDR     = CSR_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear_error,
  input  logic [31:0] period,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic [1:0]  step_idx,
  output logic        error,
  output logic [7:0]  err_count
);
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);
  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d, lat_q, lat_d;
  logic        pend_q, pend_d, done_q, done_d, error_q, error_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        active, rd_fin, mismatch, expire;
  assign active   = state_q inside {WRITE, READ, WAIT_RD};
  assign rd_fin   = state_q == WAIT_RD && lat_q == 2'd0;
  assign mismatch = rd_fin && avm_readdata != pattern(step_q);
  led_seq_timer u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (rd_fin),
    .value  (period),
    .expire (expire)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start && !stop ? WRITE : IDLE;
      WRITE:   state_d = avm_waitrequest ? WRITE : READ;
      READ:    state_d = avm_waitrequest ? READ : WAIT_RD;
      WAIT_RD: state_d = !rd_fin ? WAIT_RD : (pend_q || stop) ? IDLE : DWELL;
      DWELL:   state_d = stop ? IDLE : expire ? WRITE : DWELL;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    avm_chipselect = state_q == WRITE || state_q == READ;
    avm_write      = state_q == WRITE;
    avm_read       = state_q == READ;
    avm_address    = avm_chipselect ? CSR_ADDR : 2'b00;
    avm_writedata  = avm_write ? pattern(step_q) : 32'd0;
    busy           = state_q != IDLE;
  end
  // The step advances on every new write except the very first one after reset
  always_comb begin
    pend_d  = active && state_d != IDLE && (pend_q || stop);
    lat_d   = state_q == READ ? LAT_LOAD : state_q == WAIT_RD && lat_q != 2'd0 ? lat_q - 2'd1 : lat_q;
    done_d  = done_q | rd_fin;
    step_d  = state_d == WRITE && (state_q == DWELL || (state_q == IDLE && done_q)) ? next_idx(step_q) : step_q;
    error_d = mismatch | (error_q & ~clear_error);
    cnt_d   = mismatch ? (clear_error ? 8'd1 : cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1) : clear_error ? 8'd0 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      step_q  <= '0;
      lat_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      step_q  <= step_d;
      lat_q   <= lat_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  assign step_idx  = step_q;
  assign error     = error_q;
  assign err_count = cnt_q;
endmodule
